// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access; data has priority.
// Optional IF anti-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

   state_t            state_reg, state_next;
   logic              owner_dm_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] if_rdata_reg;
   logic [DATA_W-1:0] dm_rdata_reg;
   logic              grant_i;
   logic              grant_d;
   logic              force_if;
   logic              busy;

   if (STARVE_LIMIT < 1) begin : g_limit_check
      $error("STARVE_LIMIT must be at least 1");
   end

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_reg;

   // Counts data grants that overtook a waiting fetch; saturates at the limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_reg <= '0;
      end else if (grant_i) begin
         starve_cnt_reg <= '0;
      end else if (grant_d && if_req && (starve_cnt_reg != CNT_W'(STARVE_LIMIT))) begin
         starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
      end
   end

   assign force_if = if_req && (starve_cnt_reg == CNT_W'(STARVE_LIMIT));
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (force_if) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end else if (dm_req) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end else if (if_req) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         owner_dm_reg <= 1'b0;
         we_reg       <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         if_rdata_reg <= '0;
         dm_rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (grant_i) begin
            owner_dm_reg <= 1'b0;
            we_reg       <= 1'b0;
            addr_reg     <= if_addr;
            wdata_reg    <= '0;
         end else if (grant_d) begin
            owner_dm_reg <= 1'b1;
            we_reg       <= dm_we;
            addr_reg     <= dm_addr;
            wdata_reg    <= dm_wdata;
         end
         if ((state_reg == BUSY_I) && mem_ready) begin
            if_rdata_reg <= mem_rdata;
         end
         // Stores leave the previous load data visible on dm_rdata.
         if ((state_reg == BUSY_D) && mem_ready && !we_reg) begin
            dm_rdata_reg <= mem_rdata;
         end
      end
   end

   assign busy      = (state_reg == BUSY_I) || (state_reg == BUSY_D);
   assign mem_req   = busy;
   assign mem_we    = busy && we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign if_ack    = (state_reg == DONE) && !owner_dm_reg;
   assign dm_ack    = (state_reg == DONE) && owner_dm_reg;
   assign if_rdata  = if_rdata_reg;
   assign dm_rdata  = dm_rdata_reg;
   assign stall_if  = if_req && !if_ack;
   assign stall_mem = dm_req && !dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory model, per-port scoreboards, scenario tasks.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        stall_if;
   logic        stall_mem;

   logic        auto_mem;
   logic        model_ready;
   logic [31:0] model_rdata;
   logic        man_ready;
   logic [31:0] man_rdata;
   int          mem_wait;
   int          wcnt;
   int          cyc;
   int          n_checks;
   int          n_fail;
   logic [31:0] last_dm;
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] if_q [$];
   logic [31:0] dm_q [$];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_ready = auto_mem ? model_ready : man_ready;
   assign mem_rdata = auto_mem ? model_rdata : man_rdata;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // Memory model: answers a strobe after mem_wait extra cycles.
   always @(negedge clk) begin
      if (mem_req) begin
         if (wcnt == mem_wait) begin
            model_ready = 1'b1;
            model_rdata = mem_we ? 32'h0 : rd_model(mem_addr);
            if (mem_we) mem_arr[mem_addr] = mem_wdata;
         end else begin
            model_ready = 1'b0;
         end
         wcnt = wcnt + 1;
      end else begin
         model_ready = 1'b0;
         wcnt = 0;
      end
   end

   // Scoreboard: every ack pops the expected read data of its port.
   always @(negedge clk) begin
      if (!reset) begin
         if (if_ack) begin
            n_checks++;
            if (if_q.size() == 0) begin
               n_fail++;
               $display("FAIL if_ack_unexpected: got if_ack=1 rdata=%h, required no ack", if_rdata);
            end else begin
               logic [31:0] e;
               e = if_q.pop_front();
               if (if_rdata !== e) begin
                  n_fail++;
                  $display("FAIL if_rdata_sb: got %h, required %h", if_rdata, e);
               end
            end
         end
         if (dm_ack) begin
            n_checks++;
            if (dm_q.size() == 0) begin
               n_fail++;
               $display("FAIL dm_ack_unexpected: got dm_ack=1 rdata=%h, required no ack", dm_rdata);
            end else begin
               logic [31:0] e;
               e = dm_q.pop_front();
               if (dm_rdata !== e) begin
                  n_fail++;
                  $display("FAIL dm_rdata_sb: got %h, required %h", dm_rdata, e);
               end
            end
         end
      end
   end

   task automatic do_access(input bit is_dm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int req_cyc, output int ack_cyc);
      @(posedge clk); #1;
      req_cyc = cyc;
      if (is_dm) begin
         dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_req = 1'b1;
         if (!we) last_dm = rd_model(addr);
         dm_q.push_back(last_dm);
      end else begin
         if_addr = addr; if_req = 1'b1;
         if_q.push_back(rd_model(addr));
      end
      ack_cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (is_dm ? dm_ack : if_ack) begin
            ack_cyc = cyc;
            break;
         end
      end
      if (ack_cyc < 0) begin
         n_checks++; n_fail++;
         $display("FAIL ack_timeout: got no ack for addr %h, required ack within 40 cycles", addr);
      end
      @(posedge clk); #1;
      if (is_dm) dm_req = 1'b0;
      else if_req = 1'b0;
      $display("txn %s addr=%h we=%0d req@%0d ack@%0d", is_dm ? "DM" : "IF", addr, we, req_cyc, ack_cyc);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, if_ack, dm_ack, stall_if, stall_mem} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 000000", {mem_req, mem_we, if_ack, dm_ack, stall_if, stall_mem});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h %h, required all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      $display("txn reset released at cycle %0d", cyc);
   endtask

   task automatic test_fetch();
      @(posedge clk); #1;
      if_addr = 32'h0000_0040; if_req = 1'b1;
      if_q.push_back(32'h2008_0005);
      @(negedge clk);
      n_checks++;
      if (stall_if !== 1'b1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_n: got stall_if=%b mem_req=%b, required 1 0", stall_if, mem_req);
      end
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_n1: got req=%b addr=%h we=%b, required 1 00000040 0", mem_req, mem_addr, mem_we);
      end
      @(negedge clk);
      n_checks++;
      if (if_ack !== 1'b1 || if_rdata !== 32'h2008_0005 || stall_if !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_n2: got ack=%b rdata=%h stall=%b req=%b, required 1 20080005 0 0",
                  if_ack, if_rdata, stall_if, mem_req);
      end
      @(posedge clk); #1;
      if_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_ack !== 1'b0 || stall_if !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_after: got ack=%b stall=%b, required 0 0", if_ack, stall_if);
      end
      $display("txn IF fetch addr=00000040 data=20080005 checked");
   endtask

   task automatic test_store();
      int rq, ak;
      do_access(1'b1, 1'b0, 32'h200, 32'h0, rq, ak);
      mem_wait = 2;
      @(posedge clk); #1;
      dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
      dm_q.push_back(last_dm);
      @(negedge clk);
      n_checks++;
      if (stall_mem !== 1'b1) begin
         n_fail++;
         $display("FAIL store_stall: got %b, required 1", stall_mem);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 ||
             mem_wdata !== 32'hDEAD_BEEF || dm_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL store_busy%0d: got req=%b we=%b addr=%h wdata=%h ack=%b, required 1 1 00000100 deadbeef 0",
                     i, mem_req, mem_we, mem_addr, mem_wdata, dm_ack);
         end
         if (i == 0) begin
            dm_addr = 32'h999; dm_wdata = 32'h0;
         end
      end
      @(negedge clk);
      n_checks++;
      if (dm_ack !== 1'b1 || dm_rdata !== last_dm || mem_req !== 1'b0 || stall_mem !== 1'b0) begin
         n_fail++;
         $display("FAIL store_done: got ack=%b rdata=%h req=%b stall=%b, required 1 %h 0 0",
                  dm_ack, dm_rdata, mem_req, stall_mem, last_dm);
      end
      @(posedge clk); #1;
      dm_req = 1'b0; dm_we = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dm_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL store_ack_once: got %b, required 0", dm_ack);
      end
      mem_wait = 0;
      $display("txn DM store addr=00000100 data=deadbeef checked");
      do_access(1'b1, 1'b0, 32'h100, 32'h0, rq, ak);
   endtask

   task automatic test_both();
      int dr, da, ir, ia;
      fork
         do_access(1'b1, 1'b0, 32'h300, 32'h0, dr, da);
         do_access(1'b0, 1'b0, 32'h80, 32'h0, ir, ia);
      join
      n_checks++;
      if (da - dr !== 2 || ia - da !== 3) begin
         n_fail++;
         $display("FAIL both_order: got dm_ack +%0d, if_ack +%0d after dm_ack, required +2 and +3", da - dr, ia - da);
      end
   endtask

   task automatic test_reset_mid();
      auto_mem = 1'b0; man_ready = 1'b0;
      @(posedge clk); #1;
      dm_we = 1'b0; dm_addr = 32'h700; dm_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
         n_fail++;
         $display("FAIL rst_busy: got req=%b addr=%h, required 1 00000700", mem_req, mem_addr);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; dm_req = 1'b0; man_ready = 1'b1; man_rdata = 32'hBAD0_0BAD;
      @(negedge clk);
      n_checks++;
      if ({mem_req, mem_we, if_ack, dm_ack} !== 4'b0 ||
          {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
         n_fail++;
         $display("FAIL rst_mid_vals: got req=%b we=%b acks=%b%b addr=%h wd=%h ird=%h drd=%h, required all 0",
                  mem_req, mem_we, if_ack, dm_ack, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      @(posedge clk); #1;
      man_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dm_ack !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_late_ready: got ack=%b req=%b rdata=%h, required 0 0 0", dm_ack, mem_req, dm_rdata);
      end
      last_dm = 32'h0;
      auto_mem = 1'b1;
      $display("txn reset during BUSY_D checked");
   endtask

   task automatic test_idle_ready();
      int rq, ak;
      auto_mem = 1'b0;
      @(posedge clk); #1;
      man_ready = 1'b1; man_rdata = 32'h5555_AAAA;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || if_ack !== 1'b0 || dm_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: got req=%b acks=%b%b, required 0 00", mem_req, if_ack, dm_ack);
      end
      @(posedge clk); #1;
      man_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if_ack !== 1'b0 || dm_ack !== 1'b0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_ready_after: got acks=%b%b ird=%h drd=%h, required 00 0 0", if_ack, dm_ack, if_rdata, dm_rdata);
      end
      auto_mem = 1'b1;
      do_access(1'b0, 1'b0, 32'h0000_0040, 32'h0, rq, ak);
      n_checks++;
      if (ak - rq !== 2) begin
         n_fail++;
         $display("FAIL idle_latency: got %0d, required 2", ak - rq);
      end
   endtask

   task automatic test_starvation();
      string seq, exp_seq;
      int dcnt, icnt;
      bit drop_d, drop_i, done;
`ifdef ARB_STARVE_GUARD_EN
      exp_seq = "DDDDID";
`else
      exp_seq = "DDDDDI";
`endif
      seq = ""; dcnt = 0; icnt = 0; drop_d = 0; drop_i = 0; done = 0;
      for (int i = 0; i < 5; i++) dm_q.push_back(rd_model(32'h500));
      if_q.push_back(rd_model(32'h600));
      @(posedge clk); #1;
      dm_we = 1'b0; dm_addr = 32'h500; dm_req = 1'b1;
      if_addr = 32'h600; if_req = 1'b1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (dm_ack) begin seq = {seq, "D"}; dcnt++; if (dcnt == 5) drop_d = 1; end
         if (if_ack) begin seq = {seq, "I"}; icnt++; drop_i = 1; end
         if (dcnt == 5 && icnt == 1) done = 1;
         @(posedge clk); #1;
         if (drop_d) dm_req = 1'b0;
         if (drop_i) if_req = 1'b0;
      end
      dm_req = 1'b0; if_req = 1'b0;
      n_checks++;
      if (seq != exp_seq) begin
         n_fail++;
         $display("FAIL grant_sequence: got %s, required %s", seq, exp_seq);
      end
      $display("txn contention grant sequence %s", seq);
   endtask

   initial begin
      cyc = 0; n_checks = 0; n_fail = 0; last_dm = 32'h0;
      reset = 1'b1; if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
      dm_addr = 32'h0; dm_wdata = 32'h0;
      auto_mem = 1'b1; man_ready = 1'b0; man_rdata = 32'h0;
      model_ready = 1'b0; model_rdata = 32'h0; mem_wait = 0; wcnt = 0;
      mem_arr[32'h40] = 32'h2008_0005;
      test_reset();
      test_fetch();
      test_store();
      test_both();
      test_reset_mid();
      test_idle_ready();
      test_starvation();
      repeat (3) @(posedge clk);
      n_checks++;
      if (if_q.size() != 0 || dm_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d IF and %0d DM pending, required 0 0", if_q.size(), dm_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
